l1c_fill_master: RTL
====================

Name: l1c_fill_master

Overview:
Memory-side responder for the L1 instruction cache miss interface (req/addr/wait/out). It accepts one line-fill request, fetches the 16-byte line with one AXI4 INCR read burst, and buffers all four beats. It then streams the words to the cache in descending offset order (word 3, 2, 1, 0) on four consecutive cycles with c_wait low. It sits inside the CPU wrapper, between the I-cache and the bus read channels.

Parameters:
ID_W, 4, AXI ID width
AR_ID, 0, ARID driven on every request
LINE_WORDS, 4, words per line; fixed at 4, any other value is unsupported

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
c_req  in  1  fill request from cache, held high until drain completes
c_addr  in  32  miss address; bits [3:0] ignored
c_write  in  1  must be 0; I-side is read-only
c_in  in  32  unused; I-side is read-only
c_type  in  3  unused, ignored
c_out  out  32  fill word to cache
c_wait  out  1  0 = c_out valid this cycle
ARID  out  ID_W  = AR_ID
ARADDR  out  32  {latched c_addr[31:4], 4'b0}
ARLEN  out  4  constant 4'd3
ARSIZE  out  3  constant 3'b010
ARBURST  out  2  constant 2'b01 (INCR)
ARVALID  out  1  address valid
ARREADY  in  1  address accept
RID  in  ID_W  read ID
RDATA  in  32  read data
RRESP  in  2  read response
RLAST  in  1  last beat
RVALID  in  1  data valid
RREADY  out  1  data accept
err  out  1  sticky protocol/response error

Behaviour:
- Reset values: state IDLE, ARVALID=0, RREADY=0, c_wait=1, c_out=0, err=0, line buffer=0, beat counter=0.
- FSM states:
  - IDLE: on c_req=1 && c_write=0, latch c_addr[31:4] and go to AR.
  - AR: ARVALID=1 and held stable; on ARREADY go to RD.
  - RD: RREADY=1; on each RVALID beat, store RDATA at buf[beat] and increment beat. When beat 3 is accepted, go to DRAIN.
  - DRAIN: 4 cycles, k=0..3; c_wait=0 and c_out=buf[3-k]. After k=3, go to IDLE.
- c_wait is 1 in every state except DRAIN. c_wait is never toggled inside DRAIN, because the cache requires 4 consecutive low cycles.
- Minimum latency: c_req sampled at T -> ARVALID at T+1. With ARREADY at T+1 and beats at T+2..T+5, c_wait is low at T+6..T+9.
- Back-to-back: IDLE may accept a new c_req on the cycle after the last DRAIN cycle.
- ARVALID stays asserted until ARREADY. ARADDR and ARID do not change while ARVALID=1.
- RVALID gaps: beats are counted only on RVALID && RREADY; bubbles simply extend RD.
- err is set (sticky until reset) on any of:
  - RRESP != 2'b00; the data is still stored and delivered.
  - RID != AR_ID on an accepted beat.
  - RLAST=1 on beats 0-2, or RLAST=0 on beat 3.
  - The beat counter alone decides when RD ends.
- c_req=1 with c_write=1 in IDLE: the request is not accepted, err is set, c_wait stays 1.
- c_req dropping during AR, RD or DRAIN does not abort the transfer; the burst completes and DRAIN still runs.
- rst_n low at any point returns all outputs to reset values immediately. A bus transaction left outstanding is the interconnect's responsibility.

Optional Feature:
- Macro: L1C_FILL_PERF_EN.
- When defined:
  - 32-bit output fill_cnt increments once per entry into DRAIN.
  - 32-bit output fill_lat_cnt increments every cycle the state is AR or RD.
  - Both reset to 0 and wrap silently.
- When undefined: neither port nor register exists.

Decomposition:
- Package l1c_fill_pkg holds:
  - state enum {IDLE, AR, RD, DRAIN}
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00, LEN_LINE=4'd3
  - LINE_WORDS=4
- One sub-module, l1c_line_buf: 4x32 register file with write port (wr_en, wr_idx) and combinational read port (rd_idx). The FSM drives rd_idx = 3-k.

Test Plan:
- Nominal: c_addr=0x0000_1234, ARREADY immediate, RDATA=A0,A1,A2,A3 -> ARADDR=0x0000_1230, ARLEN=3; c_wait low 4 consecutive cycles with c_out=A3,A2,A1,A0; err=0.
- Stalls: ARREADY delayed 5 cycles, RVALID with 2-cycle bubbles between beats -> same 4-cycle reverse drain, no early c_wait=0.
- Error: beat 1 RRESP=2'b10 and RLAST on beat 2 -> all 4 words still delivered, err=1 and stays 1 across a following clean fill.
- Reset mid-RD after 2 beats -> ARVALID=0, RREADY=0, c_wait=1 immediately; the next request fetches cleanly.
- Back-to-back fills to 0x100 then 0x200 -> second ARVALID asserted 1 cycle after first drain ends. With L1C_FILL_PERF_EN and zero-wait bus: fill_cnt=2, fill_lat_cnt=10 (5 AR/RD cycles per fill).
- c_req with c_write=1 -> no ARVALID, c_wait stays 1, err=1.

Source files
------------

// File: rtl/l1c_fill_pkg.sv
// l1c_fill_pkg: shared states and AXI constants for the I-cache line-fill master.
// Optional perf counters in l1c_fill_master are enabled with L1C_FILL_PERF_EN.
package l1c_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    RD,
    DRAIN
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] LEN_LINE   = 4'd3;
  localparam int         LINE_WORDS = 4;

endpackage

// File: rtl/l1c_line_buf.sv
// l1c_line_buf: small line register file.
// One write port, one combinational read port.
module l1c_line_buf
  import l1c_fill_pkg::*;
#(
  parameter int WORDS = LINE_WORDS,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] mem_d [WORDS];

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/l1c_fill_master.sv
// l1c_fill_master: I-cache miss responder, one AXI INCR burst per line,
// drained to the cache in descending word order. Perf counters: L1C_FILL_PERF_EN.
module l1c_fill_master
  import l1c_fill_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int AR_ID      = 0,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            c_req,
  input  logic [31:0]     c_addr,
  input  logic            c_write,
  input  logic [31:0]     c_in,
  input  logic [2:0]      c_type,
  output logic [31:0]     c_out,
  output logic            c_wait,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY,
  output logic            err
`ifdef L1C_FILL_PERF_EN
  ,
  output logic [31:0]     fill_cnt,
  output logic [31:0]     fill_lat_cnt
`endif
);

  localparam logic [ID_W-1:0] ID_L = ID_W'(AR_ID);

  state_e      state_q, state_d;
  logic [27:0] addr_q, addr_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  k_q, k_d;
  logic        err_q, err_d;
  logic        wr_en;
  logic [1:0]  rd_idx;
  logic [31:0] rd_data;

  logic unused_in;
  assign unused_in = ^{c_in, c_type};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    k_d     = k_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_req && c_write) begin
          err_d = 1'b1;
        end else if (c_req) begin
          addr_d  = c_addr[31:4];
          beat_d  = 2'd0;
          state_d = AR;
        end
      end
      AR: begin
        if (ARREADY) begin
          state_d = RD;
        end
      end
      RD: begin
        if (RVALID) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 2'd1;
          // Bad beats are still stored; only the error flag records them.
          if (RRESP != RESP_OKAY || RID != ID_L ||
              RLAST != (beat_q == 2'd3)) begin
            err_d = 1'b1;
          end
          if (beat_q == 2'd3) begin
            k_d     = 2'd0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  l1c_line_buf #(
    .WORDS(LINE_WORDS)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (beat_q),
    .wr_data(RDATA),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  assign rd_idx  = 2'd3 - k_q;
  assign c_wait  = (state_q != DRAIN);
  assign c_out   = (state_q == DRAIN) ? rd_data : '0;
  assign ARVALID = (state_q == AR);
  assign RREADY  = (state_q == RD);
  assign ARID    = ID_L;
  assign ARADDR  = {addr_q, 4'h0};
  assign ARLEN   = LEN_LINE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign err     = err_q;

`ifdef L1C_FILL_PERF_EN
  logic [31:0] fill_cnt_q, fill_cnt_d;
  logic [31:0] lat_cnt_q, lat_cnt_d;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    if (state_q != DRAIN && state_d == DRAIN) begin
      fill_cnt_d = fill_cnt_q + 32'd1;
    end
    if (state_q == AR || state_q == RD) begin
      lat_cnt_d = lat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign fill_cnt     = fill_cnt_q;
  assign fill_lat_cnt = lat_cnt_q;
`endif

endmodule
